// File: rtl/rs1_ofst_gen_if.sv
// Decode-window and load-operand bundle between the IFU byte window and the local-variable load decoder.
// Latency: none, this file only groups the wires.
// Backpressure: hold is carried here; consume tells the IFU how far to shift the window.
interface rs1_ofst_gen_if;
  logic [7:0]  opcode;
  logic [7:0]  byte1;
  logic [7:0]  byte2;
  logic [2:0]  valid;
  logic        hold;
  logic [31:0] vars_base;
  logic [1:0]  consume;
  logic        ld_valid;
  logic [15:0] ld_offset;
  logic        ld_double;
  logic [31:0] ld_addr;
  logic        wide_q;

  // IFU side: presents the window and receives the decoded load
  modport master (
    output opcode, byte1, byte2, valid, hold, vars_base,
    input  consume, ld_valid, ld_offset, ld_double, ld_addr, wide_q
  );

  // Decoder side
  modport slave (
    input  opcode, byte1, byte2, valid, hold, vars_base,
    output consume, ld_valid, ld_offset, ld_double, ld_addr, wide_q
  );
endinterface

// File: rtl/rs1_ofst_gen.sv
// Local-variable load decoder: short, index and wide-index forms -> offset, width, VARS word address.
// Latency: consume is combinational; ld_* and wide_q are registered, one cycle after the decode.
// Backpressure: hold freezes all state and outputs and forces consume to 0.
module rs1_ofst_gen (
  input  logic         clk,
  input  logic         reset,
  rs1_ofst_gen_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    WIDE = 1'b1
  } state_t;

  state_t      state;
  state_t      next_state;

  logic        ld_valid_r;
  logic [15:0] ld_offset_r;
  logic        ld_double_r;
  logic [31:0] ld_addr_r;

  logic        is_short;
  logic        is_index;
  logic        is_wide;
  logic [2:0]  short_rel;

  logic        dec_load;
  logic [15:0] dec_offset;
  logic        dec_double;
  logic [1:0]  dec_consume;

  // Opcode classification. Short-form families are 4 apart starting at 0x1a,
  // so the low bits of (opcode - 0x1a) give the index and the family parity
  // (bit 2) marks the lload/dload families.
  assign is_short  = (bus.opcode >= 8'h1a) && (bus.opcode <= 8'h2d);
  assign is_index  = (bus.opcode >= 8'h15) && (bus.opcode <= 8'h19);
  assign is_wide   = (bus.opcode == 8'hc4);
  assign short_rel = 3'(bus.opcode - 8'h1a);

  // Decode the window head against the current prefix state
  always_comb begin
    dec_load    = 1'b0;
    dec_offset  = 16'h0000;
    dec_double  = 1'b0;
    dec_consume = 2'd0;
    next_state  = state;
    case (state)
      IDLE: begin
        if (is_short && bus.valid[0]) begin
          dec_load    = 1'b1;
          dec_offset  = {14'd0, short_rel[1:0]};
          dec_double  = short_rel[2];
          dec_consume = 2'd1;
        end else if (is_index && (bus.valid[1:0] == 2'b11)) begin
          dec_load    = 1'b1;
          dec_offset  = {8'h00, bus.byte1};
          // 0x16 lload and 0x18 dload are the even index-form opcodes
          dec_double  = ~bus.opcode[0];
          dec_consume = 2'd2;
        end else if (is_wide && bus.valid[0]) begin
          dec_consume = 2'd1;
          next_state  = WIDE;
        end
      end
      WIDE: begin
        if (bus.valid[0]) begin
          if (is_index) begin
            if (bus.valid == 3'b111) begin
              dec_load    = 1'b1;
              dec_offset  = {bus.byte1, bus.byte2};
              dec_double  = ~bus.opcode[0];
              dec_consume = 2'd3;
              next_state  = IDLE;
            end
          end else begin
            // Not ours: leave the opcode in the window for the store/iinc
            // decoders, which see the prefix through wide_q this cycle.
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM and registered load operand; offset/width/address keep the last load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ld_valid_r  <= 1'b0;
      ld_offset_r <= 16'h0000;
      ld_double_r <= 1'b0;
      ld_addr_r   <= 32'h0000_0000;
    end else if (!bus.hold) begin
      state      <= next_state;
      ld_valid_r <= dec_load;
      if (dec_load) begin
        ld_offset_r <= dec_offset;
        ld_double_r <= dec_double;
        ld_addr_r   <= bus.vars_base - {14'd0, dec_offset, 2'b00};
      end
    end
  end

  assign bus.consume   = (reset || bus.hold) ? 2'd0 : dec_consume;
  assign bus.ld_valid  = ld_valid_r;
  assign bus.ld_offset = ld_offset_r;
  assign bus.ld_double = ld_double_r;
  assign bus.ld_addr   = ld_addr_r;
  assign bus.wide_q    = (state == WIDE);

endmodule

// File: tb/tb_rs1_ofst_gen.sv
// Bench for rs1_ofst_gen: directed literal checks plus randomized windows against a behavioural model.
// Latency: model mirrors one-cycle registered load outputs.
// Backpressure: hold is exercised both directed and randomly.
module tb_rs1_ofst_gen;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic cmp_en = 1'b0;

  rs1_ofst_gen_if bus();

  rs1_ofst_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic        m_wide = 1'b0;
  logic        m_vld  = 1'b0;
  logic [15:0] m_off  = 16'h0;
  logic        m_dbl  = 1'b0;
  logic [31:0] m_addr = 32'h0;

  logic        e_load;
  logic [15:0] e_off;
  logic        e_dbl;
  int          e_cons;
  logic        e_next_wide;

  always @* begin
    int op;
    op          = int'(bus.opcode);
    e_load      = 1'b0;
    e_off       = 16'h0;
    e_dbl       = 1'b0;
    e_cons      = 0;
    e_next_wide = m_wide;
    if (!m_wide) begin
      if (op >= 26 && op <= 45 && bus.valid[0]) begin
        e_load = 1'b1;
        e_off  = 16'((op - 26) % 4);
        e_dbl  = (((op - 26) / 4) % 2) == 1;
        e_cons = 1;
      end else if (op >= 21 && op <= 25 && bus.valid[0] && bus.valid[1]) begin
        e_load = 1'b1;
        e_off  = 16'(bus.byte1);
        e_dbl  = ((op - 21) % 2) == 1;
        e_cons = 2;
      end else if (op == 196 && bus.valid[0]) begin
        e_cons      = 1;
        e_next_wide = 1'b1;
      end
    end else if (bus.valid[0]) begin
      if (op >= 21 && op <= 25) begin
        if (bus.valid == 3'b111) begin
          e_load      = 1'b1;
          e_off       = 16'(int'(bus.byte1) * 256 + int'(bus.byte2));
          e_dbl       = ((op - 21) % 2) == 1;
          e_cons      = 3;
          e_next_wide = 1'b0;
        end
      end else begin
        e_next_wide = 1'b0;
      end
    end
    if (reset || bus.hold) e_cons = 0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_wide <= 1'b0;
      m_vld  <= 1'b0;
      m_off  <= 16'h0;
      m_dbl  <= 1'b0;
      m_addr <= 32'h0;
    end else if (!bus.hold) begin
      m_wide <= e_next_wide;
      m_vld  <= e_load;
      if (e_load) begin
        m_off  <= e_off;
        m_dbl  <= e_dbl;
        m_addr <= bus.vars_base - 32'(e_off) * 32'd4;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("consume",   32'(bus.consume),   32'(e_cons));
      chk("ld_valid",  32'(bus.ld_valid),  32'(m_vld));
      chk("wide_q",    32'(bus.wide_q),    32'(m_wide));
      chk("ld_offset", 32'(bus.ld_offset), 32'(m_off));
      chk("ld_double", 32'(bus.ld_double), 32'(m_dbl));
      chk("ld_addr",   bus.ld_addr,        m_addr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [2:0] v, input logic h, input logic [31:0] vb);
    @(posedge clk);
    #2;
    bus.opcode    = op;
    bus.byte1     = b1;
    bus.byte2     = b2;
    bus.valid     = v;
    bus.hold      = h;
    bus.vars_base = vb;
  endtask

  task automatic idle(input logic [31:0] vb);
    drive(8'h00, 8'h00, 8'h00, 3'b000, 1'b0, vb);
  endtask

  initial begin
    bus.opcode    = 8'h00;
    bus.byte1     = 8'h00;
    bus.byte2     = 8'h00;
    bus.valid     = 3'b000;
    bus.hold      = 1'b0;
    bus.vars_base = 32'h0;
    #1 reset = 1'b1;
    #1 cmp_en = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_ld_valid", 32'(bus.ld_valid), 32'd0);
    chk("rst_wide_q",   32'(bus.wide_q),   32'd0);
    chk("rst_ld_addr",  bus.ld_addr,       32'd0);
    chk("rst_consume",  32'(bus.consume),  32'd0);
    @(posedge clk); #2 reset = 1'b0;

    // short form 0x1c -> iload_2
    drive(8'h1c, 8'h00, 8'h00, 3'b001, 1'b0, 32'h1000);
    @(negedge clk); chk("short_consume", 32'(bus.consume), 32'd1);
    idle(32'h1000);
    @(negedge clk);
    chk("short_vld",   32'(bus.ld_valid),  32'd1);
    chk("short_off",   32'(bus.ld_offset), 32'd2);
    chk("short_dbl",   32'(bus.ld_double), 32'd0);
    chk("short_addr",  bus.ld_addr,        32'h0000_0FF8);
    chk("model_addr",  m_addr,             32'h0000_0FF8);

    // index form dload 5
    drive(8'h18, 8'h05, 8'h00, 3'b011, 1'b0, 32'h1000);
    @(negedge clk); chk("idx_consume", 32'(bus.consume), 32'd2);
    idle(32'h1000);
    @(negedge clk);
    chk("idx_off",  32'(bus.ld_offset), 32'd5);
    chk("idx_dbl",  32'(bus.ld_double), 32'd1);
    chk("idx_addr", bus.ld_addr,        32'h0000_0FEC);

    // index form short of bytes
    drive(8'h18, 8'h05, 8'h00, 3'b001, 1'b0, 32'h1000);
    @(negedge clk); chk("part_consume", 32'(bus.consume), 32'd0);
    idle(32'h1000);
    @(negedge clk); chk("part_vld", 32'(bus.ld_valid), 32'd0);

    // wide iload 0x0123
    drive(8'hc4, 8'h00, 8'h00, 3'b001, 1'b0, 32'h1000);
    @(negedge clk); chk("wide_pfx_consume", 32'(bus.consume), 32'd1);
    drive(8'h15, 8'h01, 8'h23, 3'b111, 1'b0, 32'h1000);
    @(negedge clk);
    chk("wide_q_set",    32'(bus.wide_q),  32'd1);
    chk("wide_consume",  32'(bus.consume), 32'd3);
    idle(32'h1000);
    @(negedge clk);
    chk("wide_off",    32'(bus.ld_offset), 32'h123);
    chk("wide_q_clr",  32'(bus.wide_q),    32'd0);
    chk("wide_addr",   bus.ld_addr,        32'h0000_0B74);
    chk("model_off",   32'(m_off),         32'h123);

    // wide followed by a non-load
    drive(8'hc4, 8'h00, 8'h00, 3'b001, 1'b0, 32'h1000);
    drive(8'h36, 8'h00, 8'h00, 3'b001, 1'b0, 32'h1000);
    @(negedge clk); chk("wnl_consume", 32'(bus.consume), 32'd0);
    idle(32'h1000);
    @(negedge clk);
    chk("wnl_wide_q", 32'(bus.wide_q),   32'd0);
    chk("wnl_vld",    32'(bus.ld_valid), 32'd0);

    // wide followed by partial index form
    drive(8'hc4, 8'h00, 8'h00, 3'b001, 1'b0, 32'h1000);
    drive(8'h15, 8'h01, 8'h00, 3'b011, 1'b0, 32'h1000);
    drive(8'h15, 8'h01, 8'h00, 3'b011, 1'b0, 32'h1000);
    @(negedge clk);
    chk("wpart_consume", 32'(bus.consume), 32'd0);
    chk("wpart_wide_q",  32'(bus.wide_q),  32'd1);
    drive(8'h15, 8'h00, 8'h07, 3'b111, 1'b0, 32'h1000);
    idle(32'h1000);

    // hold with a pending aload_0
    drive(8'h2a, 8'h00, 8'h00, 3'b001, 1'b0, 32'h2000);
    for (int i = 0; i < 3; i++) begin
      drive(8'h1b, 8'h00, 8'h00, 3'b001, 1'b1, 32'h2000);
      @(negedge clk);
      chk("hold_consume", 32'(bus.consume),   32'd0);
      chk("hold_vld",     32'(bus.ld_valid),  32'd1);
      chk("hold_off",     32'(bus.ld_offset), 32'd0);
    end
    drive(8'h1b, 8'h00, 8'h00, 3'b001, 1'b0, 32'h2000);
    @(negedge clk); chk("rel_consume", 32'(bus.consume), 32'd1);
    idle(32'h2000);
    @(negedge clk);
    chk("rel_off", 32'(bus.ld_offset), 32'd1);
    chk("rel_vld", 32'(bus.ld_valid),  32'd1);

    // address wrap
    drive(8'h15, 8'h05, 8'h00, 3'b011, 1'b0, 32'h4);
    idle(32'h4);
    @(negedge clk); chk("wrap_addr", bus.ld_addr, 32'hFFFF_FFF0);

    // async reset while WIDE
    drive(8'hc4, 8'h00, 8'h00, 3'b001, 1'b0, 32'h4);
    idle(32'h4);
    @(negedge clk); chk("pre_rst_wide_q", 32'(bus.wide_q), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_wide_q",  32'(bus.wide_q),   32'd0);
    chk("arst_vld",     32'(bus.ld_valid), 32'd0);
    chk("arst_addr",    bus.ld_addr,       32'd0);
    chk("arst_off",     32'(bus.ld_offset),32'd0);
    @(posedge clk); #2 reset = 1'b0;

    // randomized windows
    for (int i = 0; i < 3000; i++) begin
      logic [7:0]  op;
      logic [31:0] sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)       op = 8'($urandom_range(8'h14, 8'h2e));
      else if (sel < 6)  op = 8'hc4;
      else if (sel < 8)  op = 8'($urandom_range(8'h15, 8'h19));
      else               op = 8'($urandom);
      drive(op, 8'($urandom), 8'($urandom), 3'($urandom),
            ($urandom_range(0, 7) == 0), $urandom);
    end
    idle(32'h0);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
